serial_port: RTL and testbench

UART endpoint behind the memory-mapped serial data and status words: it takes the MMU's serial request strobes, serialises written bytes onto the TX line, and deserialises incoming RX frames into a one-byte receive buffer. It reports `serial_sendComplete_o` / `serial_receiveComplete_o` back to the MMU for the status word. The frame format is 8N1, LSB first.

---
 rtl/serial_port.sv | 242 ++++++++++++++++++++++++
 tb/tb_serial_port.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_port
// Purpose  : UART endpoint (8N1, LSB first) behind the memory-mapped serial
//            data/status words. Write strobes from the MMU start a TX frame.
//            Incoming RX frames are assembled into a one-byte receive buffer.
//            Completion flags are reported back for the status word.
// Ports    : clk                      - system clock, rising edge
//            rst                      - synchronous reset, active low
//            serial_enable_i          - qualifies readWrite / fetch_data
//            serial_readWrite_i       - 1 = write request (TX)
//            serial_fetch_data_i      - CPU is reading the data word
//            serial_dataWrite_i[15:0] - TX data, bits [7:0] are sent
//            serial_dataRead_o[15:0]  - {8'h00, rx_buf}, registered
//            serial_sendComplete_o    - 1 = TX idle, ready for a new byte
//            serial_receiveComplete_o - 1 = rx_buf holds an unread byte
//            uart_txd_o               - serial TX line, idle high
//            uart_rxd_i               - serial RX line, asynchronous
// Params   : CLKS_PER_BIT             - clocks per UART bit, must be >= 4
// Revision : 1.0 - initial release
// ============================================================================
module serial_port #(
  parameter int CLKS_PER_BIT = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_enable_i,
  input  logic        serial_readWrite_i,
  input  logic        serial_fetch_data_i,
  input  logic [15:0] serial_dataWrite_i,
  output logic [15:0] serial_dataRead_o,
  output logic        serial_sendComplete_o,
  output logic        serial_receiveComplete_o,
  output logic        uart_txd_o,
  input  logic        uart_rxd_i
);

  // Bit-period counter: wide enough to hold CLKS_PER_BIT-1.
  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  // Start bit is re-checked half a bit in, so data samples land mid-bit.
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Request qualification and edge detection
  // --------------------------------------------------------------------------
  logic w_wr;
  logic w_rd;
  logic w_wr_rise;
  logic w_rd_fall;
  logic r_wr_d;
  logic r_rd_d;

  assign w_wr      = serial_enable_i & serial_readWrite_i;
  assign w_rd      = serial_enable_i & serial_fetch_data_i;
  assign w_wr_rise = w_wr & ~r_wr_d;
  assign w_rd_fall = ~w_rd & r_rd_d;

  // Upper half of the write word is never transmitted.
  logic w_unused_data_hi;
  assign w_unused_data_hi = &{1'b0, serial_dataWrite_i[15:8]};

  // --------------------------------------------------------------------------
  // TX engine
  // --------------------------------------------------------------------------
  state_t             r_tx_state;
  logic [c_CNT_W-1:0] r_tx_cnt;
  logic [2:0]         r_tx_idx;
  logic [7:0]         r_tx_shift;
  logic               r_txd;
  logic               r_send_complete;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state      <= S_IDLE;
      r_tx_cnt        <= '0;
      r_tx_idx        <= '0;
      r_tx_shift      <= '0;
      r_txd           <= 1'b1;
      r_send_complete <= 1'b1;
      r_wr_d          <= 1'b0;
    end else begin
      // Edge history is tracked in every state so that a level held across
      // the end of a frame does not look like a fresh request.
      r_wr_d <= w_wr;
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= '0;
          r_tx_idx <= '0;
          if (w_wr_rise) begin
            r_tx_shift      <= serial_dataWrite_i[7:0];
            r_txd           <= 1'b0;
            r_send_complete <= 1'b0;
            r_tx_state      <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              // Bit 0 of the shifter is always the bit on the line; the next
              // bit is one position up until the shift takes effect.
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt        <= '0;
            r_send_complete <= 1'b1;
            r_tx_state      <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX engine
  // --------------------------------------------------------------------------
  logic               r_rx_meta;
  logic               r_rxs;
  state_t             r_rx_state;
  logic [c_CNT_W-1:0] r_rx_cnt;
  logic [2:0]         r_rx_idx;
  logic [7:0]         r_rx_shift;
  logic [7:0]         r_rx_buf;
  logic               r_rx_full;
  logic               w_rx_load;

  // A good stop bit commits the byte; this has priority over a fetch
  // completing in the same cycle so the new byte is never lost.
  assign w_rx_load = (r_rx_state == S_STOP) && (r_rx_cnt == c_BIT_LAST) && r_rxs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta  <= 1'b1;
      r_rxs      <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_buf   <= '0;
      r_rx_full  <= 1'b0;
      r_rd_d     <= 1'b0;
    end else begin
      r_rx_meta <= uart_rxd_i;
      r_rxs     <= r_rx_meta;
      r_rd_d    <= w_rd;

      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_idx <= '0;
          if (!r_rxs) begin
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == c_HALF_LAST) begin
            r_rx_cnt <= '0;
            // Line already back high at mid start bit: treat as noise.
            r_rx_state <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxs, r_rx_shift[7:1]};
            if (r_rx_idx == 3'd7) begin
              r_rx_state <= S_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            // A low stop bit is a framing error: the byte is dropped and the
            // buffer and flag are left as they were.
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          r_rx_state <= S_IDLE;
        end
      endcase

      if (w_rx_load) begin
        r_rx_buf  <= r_rx_shift;
        r_rx_full <= 1'b1;
      end else if (w_rd_fall) begin
        r_rx_full <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign serial_dataRead_o        = {8'h00, r_rx_buf};
  assign serial_sendComplete_o    = r_send_complete;
  assign serial_receiveComplete_o = r_rx_full;
  assign uart_txd_o               = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_serial_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_port
// Purpose  : Self-checking bench for serial_port. Stimulus tasks push the
//            expected TX bytes and observable RX bytes into queues; monitor
//            processes decode the TX line and watch the read port and pop
//            and compare independently.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_port;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        serial_enable = 1'b0;
  logic        serial_readWrite = 1'b0;
  logic        serial_fetch_data = 1'b0;
  logic [15:0] serial_dataWrite = 16'h0000;
  logic [15:0] serial_dataRead;
  logic        serial_sendComplete;
  logic        serial_receiveComplete;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  serial_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .serial_enable_i          (serial_enable),
    .serial_readWrite_i       (serial_readWrite),
    .serial_fetch_data_i      (serial_fetch_data),
    .serial_dataWrite_i       (serial_dataWrite),
    .serial_dataRead_o        (serial_dataRead),
    .serial_sendComplete_o    (serial_sendComplete),
    .serial_receiveComplete_o (serial_receiveComplete),
    .uart_txd_o               (uart_txd),
    .uart_rxd_i               (uart_rxd)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  // Reference state of the receive side as the CPU should see it.
  logic [7:0] model_buf  = 8'h00;
  logic       model_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_tx_idle();
    int i;
    for (i = 0; i < 4000; i++) begin
      if (serial_sendComplete === 1'b1) break;
      @(posedge clk); #1;
    end
    if (serial_sendComplete !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL tx idle timeout: sendComplete %b, required 1", serial_sendComplete);
    end
  endtask

  // Raise the write strobe for 'hold' cycles. When a frame is expected the
  // transmitter must be idle, and the start bit must appear right away.
  task automatic tx_write(input logic [15:0] word, input int hold, input bit expect_frame);
    @(posedge clk); #1;
    serial_dataWrite = word;
    serial_readWrite = 1'b1;
    if (expect_frame) tx_q.push_back(word[7:0]);
    @(posedge clk); #1;
    if (expect_frame) begin
      check("tx accept sendComplete", serial_sendComplete, 1'b0);
      check("tx accept start bit", uart_txd, 1'b0);
    end
    if (hold > 1) repeat (hold - 1) @(posedge clk);
    #1;
    serial_readWrite = 1'b0;
    serial_dataWrite = 16'($urandom);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rxd = stop;
    if (stop) begin
      if ((b != model_buf) || !model_flag) rx_q.push_back(b);
      model_buf  = b;
      model_flag = 1'b1;
    end
    repeat (CPB) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int hold);
    @(posedge clk); #1;
    serial_fetch_data = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    check("fetch data stable", serial_dataRead, {8'h00, model_buf});
    serial_fetch_data = 1'b0;
    check("fetch flag before clear", serial_receiveComplete, model_flag);
    @(posedge clk); #1;
    model_flag = 1'b0;
    check("fetch flag cleared", serial_receiveComplete, 1'b0);
  endtask

  task automatic check_rx_state(input string name);
    check({name, " flag"}, serial_receiveComplete, model_flag);
    check({name, " data"}, serial_dataRead, {8'h00, model_buf});
  endtask

  // --------------------------------------------------------------------------
  // TX monitor: decode frames at mid-bit from the line itself
  // --------------------------------------------------------------------------
  initial begin : tx_monitor
    logic [7:0] got;
    logic       start_v;
    logic       stop_v;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst && uart_txd === 1'b0) begin
        repeat (HALF) @(negedge clk);
        start_v = uart_txd;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          got[k] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        stop_v = uart_txd;
        if (tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx frame: got byte %02h, required no frame", got);
        end else begin
          exp = tx_q.pop_front();
          check("tx byte", got, exp);
          check("tx start/stop", {start_v, stop_v}, 2'b01);
        end
      end
    end
  end

  // Length of every busy period on sendComplete.
  initial begin : tx_len_monitor
    int busy = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0;
      end else if (serial_sendComplete === 1'b0) begin
        busy++;
      end else if (busy != 0) begin
        check("tx busy length", busy, 10 * CPB);
        busy = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RX monitor: every visible change of the read port consumes one entry
  // --------------------------------------------------------------------------
  initial begin : rx_monitor
    logic [15:0] prev_dr = 16'h0000;
    logic        prev_rc = 1'b0;
    logic [7:0]  exp;
    forever begin
      @(negedge clk);
      if (rst && ((serial_dataRead !== prev_dr) || (serial_receiveComplete && !prev_rc))) begin
        if (rx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx byte: got %04h, required no new byte", serial_dataRead);
        end else begin
          exp = rx_q.pop_front();
          check("rx byte", serial_dataRead, {8'h00, exp});
        end
      end
      prev_dr = serial_dataRead;
      prev_rc = serial_receiveComplete;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stimulus
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset txd", uart_txd, 1'b1);
    check("reset sendComplete", serial_sendComplete, 1'b1);
    check("reset receiveComplete", serial_receiveComplete, 1'b0);
    check("reset dataRead", serial_dataRead, 16'h0000);
    rst = 1'b1;
    serial_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte, level held for several cycles
    tx_write(16'h01A5, 5, 1'b1);
    wait_tx_idle();
    repeat (2 * CPB) @(posedge clk);

    // Second rising edge while busy is dropped
    tx_write(16'h00C3, 3, 1'b1);
    repeat (15) @(posedge clk);
    tx_write(16'h003C, 3, 1'b0);
    wait_tx_idle();
    check("tx busy write dropped", serial_sendComplete, 1'b1);
    repeat (2 * CPB) @(posedge clk);

    // Level held well past the end of the frame sends one byte only
    tx_write(16'h5A81, 12 * CPB, 1'b1);
    wait_tx_idle();
    repeat (2 * CPB) @(posedge clk);

    // RX byte and fetch
    rx_frame(8'h3C, 1'b1);
    check_rx_state("rx 3C");
    fetch(3);
    check("rx data after fetch", serial_dataRead, 16'h003C);

    // Glitch on the line
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check_rx_state("rx glitch");

    // Framing error
    rx_frame(8'h55, 1'b0);
    check_rx_state("rx framing error");

    // Overrun
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    check_rx_state("rx overrun");

    // Fetch falling edge on the same cycle as the stop-bit sample
    fork
      rx_frame(8'h33, 1'b1);
      begin
        @(posedge clk); #1;
        serial_fetch_data = 1'b1;
        repeat (2 + HALF + 9 * CPB) @(posedge clk);
        #1;
        serial_fetch_data = 1'b0;
      end
    join
    check_rx_state("rx collision");

    // Requests ignored while enable is low
    serial_enable = 1'b0;
    @(posedge clk); #1;
    serial_fetch_data = 1'b1;
    serial_readWrite  = 1'b1;
    serial_dataWrite  = 16'h0077;
    repeat (3) @(posedge clk);
    #1;
    serial_fetch_data = 1'b0;
    serial_readWrite  = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check_rx_state("rx fetch gated");
    check("tx write gated sendComplete", serial_sendComplete, 1'b1);
    check("tx write gated txd", uart_txd, 1'b1);
    serial_enable = 1'b1;
    fetch(2);

    // Randomised full-duplex traffic
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          wait_tx_idle();
          tx_write(16'($urandom), $urandom_range(1, 12 * CPB), 1'b1);
          repeat ($urandom_range(0, CPB)) @(posedge clk);
        end
        wait_tx_idle();
      end
      begin
        for (int i = 0; i < 10; i++) begin
          rx_frame(8'($urandom), ($urandom_range(0, 5) != 0));
          if ($urandom_range(0, 1) == 1) fetch($urandom_range(1, 5));
        end
      end
    join
    repeat (4 * CPB) @(posedge clk);
    #1;
    check_rx_state("rx random final");
    check("tx queue drained", tx_q.size(), 0);
    check("rx queue drained", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
